decoder_nto2n_scan: RTL

//  Parametrised, registered binary-to-one-hot decoder with enable. Generalises the 1-to-2 enable decoder to
//  SEL_W select bits / NUM_OUT outputs, and adds an auto-scan mode in which an internal counter walks the

---
 rtl/decoder_nto2n_scan_pkg.sv | 28 ++
 rtl/decoder_nto2n_scan_dwell_cnt.sv | 41 ++++
 rtl/decoder_nto2n_scan.sv | 137 +++++++++++++
 3 files changed

// File: rtl/decoder_nto2n_scan_pkg.sv
// Purpose: shared types, mode constants and the one-hot helper for the scanning decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest supported output vector (SEL_W up to 6).
    localparam int MAX_OUT = 64;

    // One-hot of idx, or all-zero when idx is not a valid output (idx >= n).
    function automatic logic [MAX_OUT-1:0] onehot(input logic [5:0] idx, input int n);
        logic [MAX_OUT-1:0] r;
        r = '0;
        if (int'(idx) < n) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_nto2n_scan_dwell_cnt.sv
// Purpose: dwell counter; counts 0..DWELL-1 and wraps, tc flags the last count.
// Latency: count updates 1 cycle after clr/inc are sampled; tc is combinational from the count.
// Backpressure: none; clr has priority over inc.
// Ports: clk, rst_n (async active-low), clr, inc, tc.
module decoder_dwell_cnt #(
    parameter int DWELL = 4,
    parameter int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With DWELL=1 LAST is 0, so tc is permanently high and the scan steps every cycle.
    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Purpose: registered N-to-2^N one-hot decoder with enable, DIRECT decode and auto-scan modes.
// Latency: 1 cycle from sampled inputs to out_y/cur_idx/wrap(/sel_err).
// Backpressure: none; inputs are sampled every cycle.
// Ports: clk, rst_n (async active-low), en, mode (0 DIRECT / 1 SCAN), sel, load,
//        out_y (one-hot or zero), cur_idx, wrap (scan wrap pulse),
//        sel_err (present only when DECODER_SEL_ERR_EN is defined).
module decoder_nto2n_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               load,
    output logic [NUM_OUT-1:0] out_y,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               wrap
`ifdef DECODER_SEL_ERR_EN
    ,
    output logic               sel_err
`endif
);

    // One bit wider than sel so NUM_OUT == 2**SEL_W is representable.
    localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

    state_e state_q, state_d;

    logic [NUM_OUT-1:0] out_y_q, out_y_d;
    logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
    logic               wrap_q, wrap_d;
    logic               sel_err_d;

    logic               scan_entry;
    logic               sel_ok;
    logic [SEL_W-1:0]   sel_clamped;
    logic [SEL_W-1:0]   idx_adv;
    logic               dwell_clr;
    logic               dwell_tc;
    logic [5:0]         idx6;
    logic [MAX_OUT-1:0] oh;

    decoder_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (dwell_clr),
        .inc   (1'b1),
        .tc    (dwell_tc)
    );

    always_comb begin
        state_d     = !en ? ST_IDLE : ((mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT);
        scan_entry  = (state_d == ST_SCAN) && (state_q != ST_SCAN);
        sel_ok      = ({1'b0, sel} < NUM_OUT_W);
        sel_clamped = sel_ok ? sel : '0;
        // Out-of-range indices (reachable via DIRECT) fall back to 0 on the next step.
        idx_adv     = (cur_idx_q >= LAST_IDX) ? '0 : cur_idx_q + 1'b1;

        cur_idx_d = cur_idx_q;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;
        dwell_clr = 1'b1;

        case (state_d)
            ST_DIRECT: begin
                cur_idx_d = sel;
                sel_err_d = !sel_ok;
            end
            ST_SCAN: begin
                if (load) begin
                    // load wins over a coincident terminal-count advance.
                    cur_idx_d = sel_clamped;
                    sel_err_d = !sel_ok;
                end else if (!scan_entry) begin
                    dwell_clr = 1'b0;
                    if (dwell_tc) begin
                        cur_idx_d = idx_adv;
                        wrap_d    = (cur_idx_q == LAST_IDX);
                    end
                end
            end
            default: begin
            end
        endcase

        // The decoded output always follows the index being registered this cycle.
        idx6               = '0;
        idx6[SEL_W-1:0]    = cur_idx_d;
        oh                 = onehot(idx6, NUM_OUT);
        out_y_d            = (state_d == ST_IDLE) ? '0 : oh[NUM_OUT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_y_q   <= '0;
            cur_idx_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_y_q   <= out_y_d;
            cur_idx_q <= cur_idx_d;
            wrap_q    <= wrap_d;
        end
    end

    assign out_y   = out_y_q;
    assign cur_idx = cur_idx_q;
    assign wrap    = wrap_q;

`ifdef DECODER_SEL_ERR_EN
    logic sel_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    // Range error is still computed for the shared decode logic; nothing observes it here.
    logic unused_sel_err;
    assign unused_sel_err = sel_err_d;
`endif

endmodule
